// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage and the iterative divider.
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per cycle; signed mode divides
// magnitudes and fixes signs on the way out. result = {remainder, quotient}.
module div #(
  parameter int DATA_W = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int WK_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WK_W-1:0]       work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic [DATA_W:0]       diff;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic            sgn);
    return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] x,
                                                   input logic            neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    diff       = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          divisor_d  = magnitude(bus.opdata2_i, bus.signed_div_i);
          work_d     = {{DATA_W{1'b0}}, magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
          neg_quot_d = bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
          neg_rem_d  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
          cnt_d      = '0;
          state_d    = (bus.opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (bus.annul_i) begin
          state_d  = IDLE;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          // Borrow out of the trial subtraction means the divisor did not fit
          if (diff[DATA_W]) begin
            work_d = {work_q[WK_W-2:0], 1'b0};
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {apply_sign(work_q[2*DATA_W:DATA_W+1], neg_rem_q),
                      apply_sign(work_q[DATA_W-1:0], neg_quot_q)};
          cnt_d    = '0;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// Bench for the iterative divider: scoreboard of expected {rem, quot} pushed
// at start, popped when ready_o rises.
module tb_div;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) dif ();
  div #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(dif));

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Drive a request; caller is between edges. Expected result goes on the scoreboard.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.signed_div_i = sgn;
    dif.start_i      = 1'b1;
    sb.push_back(model(a, b, sgn));
  endtask

  // lat = edge count (edge sampling start = 1) at which ready_o was first seen, -1 if never.
  task automatic wait_ready(input int max_edges, output int lat);
    lat = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drop_start();
    dif.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    logic [63:0] exp;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dif.ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got=%b want=0", dif.ready_o);
    end
    vectors++;
    if (dif.result_o !== 64'd0) begin
      miscompares++; $display("FAIL reset_result got=%h want=0", dif.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(32'd81, 32'd9, 1'b0);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34) begin
      miscompares++; $display("FAIL first_edge_latency got=%0d want=34", lat);
    end
    vectors++;
    if (dif.result_o !== exp) begin
      miscompares++; $display("FAIL first_edge_result got=%h want=%h", dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_unsigned();
    int lat;
    logic [63:0] exp;
    issue(32'd100, 32'd7, 1'b0);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34) begin
      miscompares++; $display("FAIL udiv_latency got=%0d want=34", lat);
    end
    vectors++;
    if (dif.result_o !== 64'h00000002_0000000E || dif.result_o !== exp) begin
      miscompares++; $display("FAIL udiv_100_7 got=%h want=%h", dif.result_o, exp);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dif.ready_o !== 1'b1 || dif.result_o !== exp) begin
      miscompares++; $display("FAIL end_hold got=%b/%h want=1/%h", dif.ready_o, dif.result_o, exp);
    end
    drop_start();
    vectors++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      miscompares++; $display("FAIL end_release got=%b/%h want=0/0", dif.ready_o, dif.result_o);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] exp;
    issue(32'hFFFFFFF9, 32'h00000002, 1'b1);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34 || dif.result_o !== 64'hFFFFFFFF_FFFFFFFD || dif.result_o !== exp) begin
      miscompares++; $display("FAIL sdiv_m7_2 lat=%0d got=%h want=%h", lat, dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] exp;
    issue(32'h12345678, 32'd0, 1'b1);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 2 || dif.result_o !== exp || dif.result_o !== 64'd0) begin
      miscompares++; $display("FAIL div_zero lat=%0d got=%h want lat=2 %h", lat, dif.result_o, exp);
    end
    drop_start();
    // Annul while in BYZERO
    issue(32'd5, 32'd0, 1'b0);
    @(posedge clk); #1;
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    void'(sb.pop_front());
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    wait_ready(6, lat);
    vectors++;
    if (lat !== -1) begin
      miscompares++; $display("FAIL byzero_annul ready seen at edge %0d want never", lat);
    end
  endtask

  task automatic test_annul();
    int lat;
    logic [63:0] exp;
    issue(32'hDEADBEEF, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    void'(sb.pop_front());
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    wait_ready(40, lat);
    vectors++;
    if (lat !== -1 || dif.result_o !== 64'd0) begin
      miscompares++; $display("FAIL on_annul ready at %0d result=%h want never/0", lat, dif.result_o);
    end
    // start together with annul in IDLE must be ignored
    dif.start_i = 1'b1;
    dif.annul_i = 1'b1;
    dif.opdata1_i = 32'd9;
    dif.opdata2_i = 32'd0;
    wait_ready(5, lat);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    vectors++;
    if (lat !== -1) begin
      miscompares++; $display("FAIL idle_annul ready at %0d want never", lat);
    end
    issue(32'd50, 32'd5, 1'b0);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34 || dif.result_o !== 64'h00000000_0000000A || dif.result_o !== exp) begin
      miscompares++; $display("FAIL after_annul_50_5 lat=%0d got=%h want=%h", lat, dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_extremes();
    int lat;
    logic [63:0] exp;
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34 || dif.result_o !== 64'h00000000_80000000 || dif.result_o !== exp) begin
      miscompares++; $display("FAIL sdiv_min_m1 got=%h want=%h", dif.result_o, exp);
    end
    drop_start();
    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34 || dif.result_o !== 64'h00000000_FFFFFFFF || dif.result_o !== exp) begin
      miscompares++; $display("FAIL udiv_max_1 got=%h want=%h", dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] exp;
    issue(32'd1000, 32'd7, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    dif.start_i = 1'b0;
    void'(sb.pop_front());
    @(posedge clk); #1;
    vectors++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      miscompares++; $display("FAIL mid_reset got=%b/%h want=0/0", dif.ready_o, dif.result_o);
    end
    rst = 1'b0;
    issue(32'd9, 32'd3, 1'b0);
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 34 || dif.result_o !== 64'h00000000_00000003 || dif.result_o !== exp) begin
      miscompares++; $display("FAIL after_reset_9_3 lat=%0d got=%h want=%h", lat, dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] exp;
    issue(32'hFFFFFF9C, 32'd7, 1'b1);
    @(posedge clk); #1;
    dif.opdata1_i    = 32'h00000001;
    dif.opdata2_i    = 32'h00000000;
    dif.signed_div_i = 1'b0;
    wait_ready(40, lat);
    exp = sb.pop_front();
    vectors++;
    if (lat !== 33 || dif.result_o !== exp) begin
      miscompares++; $display("FAIL operand_change lat=%0d got=%h want=%h", lat + 1, dif.result_o, exp);
    end
    drop_start();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 12; i++) begin
      a   = $urandom;
      b   = (i % 3 == 0) ? $urandom_range(1, 20) : $urandom;
      if (i == 5) b = 32'hFFFFFFF9;
      sgn = i[0];
      issue(a, b, sgn);
      wait_ready(40, lat);
      exp = sb.pop_front();
      vectors++;
      if (lat !== 34 || dif.result_o !== exp) begin
        miscompares++;
        $display("FAIL rand_%0d a=%h b=%h s=%b lat=%0d got=%h want=%h", i, a, b, sgn, lat, dif.result_o, exp);
      end
      drop_start();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_extremes();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; result width is 2*DATA_W.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU).
REQ-005 SHALL have port opdata1_i  input  DATA_W  dividend.
REQ-006 SHALL have port opdata2_i  input  DATA_W  divisor.
REQ-007 SHALL have port start_i  input  1  request from EX stage; held high until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  cancel in-flight divide (branch/flush).
REQ-009 SHALL have port result_o  output  2*DATA_W  {remainder, quotient}; HI = remainder, LO = quotient.
REQ-010 SHALL have port ready_o  output  1  result valid.

Function
REQ-011 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-012 IDLE: start_i=1 and annul_i=0 SHALL latch operands and sign mode.
- Divisor 0: go to BYZERO.
- Otherwise: go to ON with cnt=0.
REQ-013 At latch, signed mode SHALL replace each negative operand by its magnitude (~x+1); unsigned mode SHALL use operands unchanged.
REQ-014 At latch, SHALL load the (2*DATA_W+1)-bit working register as {0…0, |dividend|, 1'b0}.
REQ-015 ON, cnt<DATA_W: each cycle SHALL compute diff = work[2W:W] - {1'b0, |divisor|}.
- diff negative: work = work<<1.
- Otherwise: work = {diff[W-1:0], work[W-1:0], 1'b1}.
- cnt increments.
REQ-016 ON, cnt==DATA_W: SHALL go to END.
- quotient = work[W-1:0], negated if signed and dividend sign differs from divisor sign.
- remainder = work[2W:W+1], negated if signed and dividend negative.
REQ-017 BYZERO SHALL go to END next cycle with result 0.
REQ-018 END SHALL drive ready_o=1 and result_o = {remainder, quotient}, both registered.
REQ-019 END with start_i=0 SHALL go to IDLE, clearing ready_o=0 and result_o=0.
REQ-020 END with start_i=1 SHALL hold END and the result.
REQ-021 annul_i=1 in ON or BYZERO SHALL go to IDLE next cycle with ready_o=0; result_o SHALL stay 0.
REQ-022 annul_i=1 together with start_i in IDLE SHALL ignore the start.
REQ-023 Latency SHALL count the edge that samples start_i as edge 1.
- Nonzero divisor: ready_o high after edge 34 (DATA_W=32).
- Zero divisor: ready_o high after edge 2.
REQ-024 Operand inputs changing after latch SHALL NOT affect the result.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wraps, no trap).
REQ-026 ready_o SHALL be high only in END.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, cnt=0, work=0, ready_o=0, result_o=0, from any state including mid-ON.
REQ-028 After rst deasserts, start_i SHALL be accepted on the first edge.

Verification
REQ-029 Unsigned 100/7, start held -> ready_o rises after edge 34, result_o = {0x00000002, 0x0000000E}; start_i dropped -> ready_o=0 next cycle.
REQ-030 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-031 Divisor 0, any dividend -> ready_o after edge 2, result_o = 0.
REQ-032 annul_i pulsed at edge 10 of a divide -> IDLE, ready_o never rises; new start 50/5 -> quotient 10, remainder 0.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-034 rst asserted at edge 20 of a divide -> ready_o=0, result_o=0 next cycle; following divide 9/3 correct with full latency.
